// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding {pc, instr} entries; flush beats push and pop.
module fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop_s  = pop_i && (count_q != '0);
    do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push_s) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; data needs no reset since count gates its use.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i && !reset) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  fetch_buffer_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_i),
    .pop_i   (pop_i),
    .flush_i (flush_i),
    .count_i (count_q)
  );

endmodule

// File: rtl/fetch_buffer_chk.sv
// Checker for the fetch buffer: a push into a full buffer without a
// matching pop means the credit scheme upstream is broken.
module fetch_buffer_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          push_i,
  input logic          pop_i,
  input logic          flush_i,
  input logic [CW-1:0] count_i
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !pop_i && !flush_i && (count_i == FULL_CNT)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited request issue to a variable-latency
// in-order memory, response buffering, and redirect with stale-response drop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int               BUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc_next
);

  localparam int            CW         = $clog2(BUF_DEPTH + 1);
  localparam int            BW         = XLEN + INSTR_W;
  localparam logic [CW:0]   CREDIT_LIM = (CW + 1)'(BUF_DEPTH);
  localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   buf_count_s;
  logic [BW-1:0]   buf_head_s;
  logic [CW:0]     credit_sum_s;
  logic [XLEN-1:0] redirect_target_s;
  logic            req_valid_s, req_fire_s, rsp_keep_s, if_valid_s, pop_s;

  // Handshake qualification and next-state for PCs and counters.
  always_comb begin
    redirect_target_s = redirect_pc & ~(XLEN'(3));
    credit_sum_s      = {1'b0, outstanding_q} + {1'b0, buf_count_s};
    req_valid_s       = !reset && !redirect_valid && (credit_sum_s < CREDIT_LIM);
    req_fire_s        = req_valid_s && imem_req_ready;
    rsp_keep_s        = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    if_valid_s        = !reset && (buf_count_s != '0);
    pop_s             = if_valid_s && if_ready;
    fetch_pc_d        = fetch_pc_q;
    rsp_pc_d          = rsp_pc_q;
    drop_cnt_d        = drop_cnt_q;
    outstanding_d     = outstanding_q + CW'(req_fire_s) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_target_s;
      rsp_pc_d   = redirect_target_s;
      // Every response still in flight after this cycle belongs to the old path.
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_keep_s) begin
        rsp_pc_d = rsp_pc_q + STEP;
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_buffer #(.WIDTH(BW), .DEPTH(BUF_DEPTH)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rsp_keep_s),
    .push_data_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i       (pop_s),
    .flush_i     (redirect_valid),
    .head_o      (buf_head_s),
    .count_o     (buf_count_s)
  );

  // Decode-facing outputs; an empty buffer presents a NOP at the next response PC.
  always_comb begin
    if (buf_count_s != '0) begin
      if_pc    = buf_head_s[BW-1:INSTR_W];
      if_instr = buf_head_s[INSTR_W-1:0];
    end else begin
      if_pc    = rsp_pc_q;
      if_instr = NOP_INSTR;
    end
    if_pc_next     = if_pc + STEP;
    if_valid       = if_valid_s;
    imem_req_valid = req_valid_s;
    imem_req_addr  = fetch_pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model
// and an in-order delivery scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr, if_pc_next;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_pc_next     (if_pc_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t       mq[$];
  vec_t        tbl[12];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          delivered = 0;
  int          reqs = 0;
  logic [31:0] exp_pc = 32'h0;
  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr, s_if_pc_next;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample, then update the memory model at posedge.
  task automatic tick(input logic rst, input logic rdy, input logic mrdy,
                      input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    reset          = rst;
    if_ready       = rdy;
    imem_req_ready = mrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (mq.size() != 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_if_valid   = if_valid;
    s_if_pc      = if_pc;
    s_if_instr   = if_instr;
    s_if_pc_next = if_pc_next;
    if (s_if_valid && rdy && !redir && !rst) begin
      delivered++;
      chk("deliver_pc", s_if_pc, exp_pc);
      chk("deliver_instr", s_if_instr, instr_of(exp_pc));
      chk("deliver_pc_next", s_if_pc_next, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else if (s_req_valid && mrdy) begin
      mq.push_back('{addr: s_req_addr, due: cyc + mem_lat});
      reqs++;
    end
    cyc++;
  endtask

  task automatic do_reset(input int lat);
    mem_lat = lat;
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    reqs      = 0;
    delivered = 0;
  endtask

  initial begin
    logic        got;
    logic [31:0] first_addr;

    reset = 1'b1; if_ready = 1'b0; imem_req_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[7]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[8]  = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
    tbl[9]  = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[10] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    tbl[11] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};

    // Reset state
    mem_lat = 1;
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_req_valid", {31'h0, s_req_valid}, 32'h0);
    chk("rst_if_valid", {31'h0, s_if_valid}, 32'h0);
    do_reset(1);
    chk("rst2_req_valid", {31'h0, s_req_valid}, 32'h0);
    chk("rst2_if_valid", {31'h0, s_if_valid}, 32'h0);
    chk("rst2_req_addr", s_req_addr, 32'h0);

    // Table: 1-cycle memory, short decode stall in the middle
    exp_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, tbl[i].rdy, 1'b1, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_req_valid", i), {31'h0, s_req_valid}, {31'h0, tbl[i].exp_rv});
      if (tbl[i].exp_rv) chk($sformatf("tbl%0d_req_addr", i), s_req_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_if_valid", i), {31'h0, s_if_valid}, {31'h0, tbl[i].exp_iv});
      if (tbl[i].exp_iv) begin
        chk($sformatf("tbl%0d_if_pc", i), s_if_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_if_instr", i), s_if_instr, instr_of(tbl[i].exp_pc));
        chk($sformatf("tbl%0d_if_pc_next", i), s_if_pc_next, tbl[i].exp_pc + 32'd4);
      end
    end

    // Long decode stall: buffer fills, requests stop, head held
    do_reset(1);
    exp_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      if (i >= 2) begin
        chk("stall_if_valid", {31'h0, s_if_valid}, 32'h1);
        chk("stall_if_pc", s_if_pc, 32'h0);
      end
    end
    chk("stall_req_count", reqs, 32'd4);
    got = 1'b0; first_addr = 32'h0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      if (s_req_valid && !got) begin
        got = 1'b1;
        first_addr = s_req_addr;
      end
    end
    chk("drain_delivered", delivered, 32'd8);
    chk("resume_seen", {31'h0, got}, 32'h1);
    chk("resume_addr", first_addr, 32'h10);

    // 3-cycle memory, two in flight, redirect to 0x100
    do_reset(3);
    exp_pc = 32'h100;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    chk("redir_no_req", {31'h0, s_req_valid}, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_req_valid", {31'h0, s_req_valid}, 32'h1);
    chk("redir_req_addr", s_req_addr, 32'h100);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_delivered_ge3", {31'h0, delivered >= 3}, 32'h1);

    // Redirect to unaligned 0x203 in the cycle a response arrives
    do_reset(1);
    exp_pc = 32'h200;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h203);
    chk("same_cyc_no_req", {31'h0, s_req_valid}, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("same_cyc_req_addr", s_req_addr, 32'h200);
    chk("same_cyc_if_valid", {31'h0, s_if_valid}, 32'h0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("same_cyc_delivered", delivered, 32'd5);

    // Two redirects two cycles apart; only the 0x80 path may reach decode
    do_reset(3);
    exp_pc = 32'h80;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("dbl_req_addr40", s_req_addr, 32'h40);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("dbl_delivered_ge3", {31'h0, delivered >= 3}, 32'h1);

    // Reset in the middle of a run with requests in flight
    mem_lat = 2;
    exp_pc  = 32'h80 + 32'd4 * delivered;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("mid_rst_req_valid", {31'h0, s_req_valid}, 32'h0);
    chk("mid_rst_if_valid", {31'h0, s_if_valid}, 32'h0);
    delivered = 0;
    exp_pc    = 32'h0;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("post_rst_req_valid", {31'h0, s_req_valid}, 32'h1);
    chk("post_rst_req_addr", s_req_addr, 32'h0);
    chk("post_rst_if_valid", {31'h0, s_if_valid}, 32'h0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("post_rst_delivered", delivered, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage that replaces the fixed PC/PC+4 loop of the single-cycle datapath. It issues PCs to an in-order, variable-latency instruction memory over a valid/ready request channel and buffers responses in a small FIFO. It presents {pc, instr, pc_next} to decode over a valid/ready handshake, and supports branch/jump redirect with flush and discard of in-flight responses.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 4, fetch-buffer entries, also the in-flight credit limit (>=2); full throughput needs BUF_DEPTH >= imem latency + 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order, one per accepted request, no backpressure
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  one-cycle redirect pulse from execute
redirect_pc  in  XLEN  redirect target; bits[1:0] ignored (forced 0)
if_valid  out  1  decode entry valid
if_ready  in  1  decode accepts entry
if_pc  out  XLEN  PC of presented instruction
if_instr  out  32  presented instruction
if_pc_next  out  XLEN  if_pc + 4

Behaviour:
- Reset (sync, priority over all inputs): fetch_pc=RESET_PC, rsp_pc=RESET_PC, buffer count=0, outstanding=0, drop_cnt=0. Outputs in the reset cycle: imem_req_valid=0, if_valid=0. imem_req_addr and if_* data drive values derived from the reset state.
- Request issue: imem_req_valid = !reset && !redirect_valid && (outstanding + count < BUF_DEPTH). imem_req_addr = fetch_pc. On handshake, fetch_pc += 4 (mod 2^XLEN) and outstanding++.
- Response: outstanding-- on every imem_rsp_valid.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise push {rsp_pc, data}, then rsp_pc += 4.
  - The credit rule guarantees the buffer never overflows. Overflow is an assertion failure.
- Output: if_valid = (count != 0), taken from the buffer head. Pop on if_valid && if_ready.
- Simultaneous push and pop in the same cycle: count is unchanged. Push into an empty buffer appears at the output the next cycle; there is no bypass.
- Redirect (cycle R):
  - Buffer flushed; the head presented in R is discarded even if if_ready=1.
  - No request is issued in R.
  - fetch_pc and rsp_pc are set to {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt = outstanding - imem_rsp_valid (the response arriving in R is itself discarded).
  - First new request goes out in R+1.
  - A redirect while drop_cnt > 0 recomputes drop_cnt by the same rule.
- Counter widths: $clog2(BUF_DEPTH+1). Dropped in-flight responses still consume credit until they return.
- Latency with a 1-cycle memory and if_ready=1:
  - reset deasserted at cycle 0 -> request at cycle 0;
  - response at cycle 1;
  - if_valid at cycle 2;
  - then one instruction per cycle.
- Decode stall (if_ready=0): the buffer fills to BUF_DEPTH, then requests stop. if_* outputs are held stable while if_valid && !if_ready.

Decomposition:
- Shared package fetch_pkg: INSTR_W=32, NOP_INSTR=32'h0000_0013, PC_STEP=4, default RESET_PC.
- Sub-module fetch_buffer: synchronous FIFO with parameters WIDTH=XLEN+32 and DEPTH=BUF_DEPTH, ports push/pop/flush/count. Flush has priority over push and pop.

Test Plan:
- Reset then run, 1-cycle memory, if_ready=1 -> if_pc sequence 0x0,0x4,0x8,... with if_valid from cycle 2; if_pc_next = if_pc+4; req addr 0x0 in cycle 0.
- Hold if_ready=0 for 10 cycles, BUF_DEPTH=4 -> exactly 4 requests issued, count=4, if_pc held at 0x0. Release -> 0x0..0xC drain in order, then fetch resumes at 0x10.
- 3-cycle memory latency, 2 requests in flight, redirect to 0x100 -> both stale responses dropped, if_pc next is 0x100, no stale instr ever reaches decode.
- Redirect to 0x203 in the same cycle a response arrives -> that response dropped, next if_pc = 0x200.
- Two redirects 2 cycles apart (0x40, then 0x80) -> only instructions from 0x80 onward delivered.
- Reset asserted mid-run with requests in flight -> all state returns to RESET_PC values, if_valid=0 in the reset cycle.
